// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers dispatched ops, wakes operands from the CDB, issues one ready op per cycle.
// Optional ALU_RS_OLDEST_FIRST_EN: an age matrix picks the oldest ready entry instead of the lowest index.

module alu_rs_entry #(
  parameter int OPW   = 4,
  parameter int DW    = 32,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             wr,
  input  logic             free,
  input  logic [OPW-1:0]   wr_op,
  input  logic [DW-1:0]    wr_src1,
  input  logic [DW-1:0]    wr_src2,
  input  logic [TAG_W-1:0] wr_tag1,
  input  logic [TAG_W-1:0] wr_tag2,
  input  logic             wr_rdy1,
  input  logic             wr_rdy2,
  input  logic [TAG_W-1:0] wr_dst,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [DW-1:0]    cdb_data,
  output logic             valid,
  output logic             ready,
  output logic [OPW-1:0]   op,
  output logic [DW-1:0]    src1,
  output logic [DW-1:0]    src2,
  output logic [TAG_W-1:0] dst
);
  logic             rdy1, rdy2;
  logic [TAG_W-1:0] tag1, tag2;

  always_ff @(posedge clk) begin
    if (clr) begin
      valid <= 1'b0;
      rdy1  <= 1'b0;
      rdy2  <= 1'b0;
      tag1  <= '0;
      tag2  <= '0;
      op    <= '0;
      src1  <= '0;
      src2  <= '0;
      dst   <= '0;
    end else if (wr) begin
      valid <= 1'b1;
      rdy1  <= wr_rdy1;
      rdy2  <= wr_rdy2;
      tag1  <= wr_tag1;
      tag2  <= wr_tag2;
      op    <= wr_op;
      src1  <= wr_src1;
      src2  <= wr_src2;
      dst   <= wr_dst;
    end else begin
      if (free) valid <= 1'b0;
      if (valid && !rdy1 && cdb_valid && cdb_tag == tag1) begin
        src1 <= cdb_data;
        rdy1 <= 1'b1;
      end
      if (valid && !rdy2 && cdb_valid && cdb_tag == tag2) begin
        src2 <= cdb_data;
        rdy2 <= 1'b1;
      end
    end
  end

  assign ready = valid & rdy1 & rdy2;
endmodule

module alu_reservation_station #(
  parameter int ENTRIES      = 4,
  parameter int ENTRY_SEL    = 2,
  parameter int TAG_W        = 6,
  parameter int ALU_OP_WIDTH = 4,
  parameter int DATA_LEN     = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    kill_i,
  input  logic                    disp_valid_i,
  output logic                    disp_ready_o,
  input  logic [ALU_OP_WIDTH-1:0] disp_op_i,
  input  logic [DATA_LEN-1:0]     disp_src1_i,
  input  logic [DATA_LEN-1:0]     disp_src2_i,
  input  logic [TAG_W-1:0]        disp_tag1_i,
  input  logic [TAG_W-1:0]        disp_tag2_i,
  input  logic                    disp_rdy1_i,
  input  logic                    disp_rdy2_i,
  input  logic [TAG_W-1:0]        disp_dst_i,
  input  logic                    cdb_valid_i,
  input  logic [TAG_W-1:0]        cdb_tag_i,
  input  logic [DATA_LEN-1:0]     cdb_data_i,
  input  logic                    ex_stall_i,
  output logic                    issue_valid_o,
  output logic [ALU_OP_WIDTH-1:0] issue_op_o,
  output logic [DATA_LEN-1:0]     issue_src1_o,
  output logic [DATA_LEN-1:0]     issue_src2_o,
  output logic [TAG_W-1:0]        issue_dst_o,
  output logic [ENTRY_SEL:0]      busy_cnt_o
);
  logic                                  clr;
  logic                                  disp_fire;
  logic                                  cap1, cap2;
  logic                                  wr_rdy1, wr_rdy2;
  logic [DATA_LEN-1:0]                   wr_src1, wr_src2;
  logic [ENTRY_SEL-1:0]                  free_idx, sel;
  logic                                  sel_valid;
  logic [ENTRIES-1:0]                    e_valid, e_ready, e_wr, e_free, cand;
  logic [ENTRIES-1:0][ALU_OP_WIDTH-1:0]  e_op;
  logic [ENTRIES-1:0][DATA_LEN-1:0]      e_src1, e_src2;
  logic [ENTRIES-1:0][TAG_W-1:0]         e_dst;

  assign clr          = reset_i | kill_i;
  assign disp_ready_o = ~&e_valid;
  assign disp_fire    = disp_valid_i & disp_ready_o;

  // An operand whose producer broadcasts in the dispatch cycle is captured directly.
  assign cap1    = ~disp_rdy1_i & cdb_valid_i & (cdb_tag_i == disp_tag1_i);
  assign cap2    = ~disp_rdy2_i & cdb_valid_i & (cdb_tag_i == disp_tag2_i);
  assign wr_rdy1 = disp_rdy1_i | cap1;
  assign wr_rdy2 = disp_rdy2_i | cap2;
  assign wr_src1 = cap1 ? cdb_data_i : disp_src1_i;
  assign wr_src2 = cap2 ? cdb_data_i : disp_src2_i;

  always_comb begin
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (!e_valid[i]) free_idx = ENTRY_SEL'(i);
  end

  always_comb begin
    e_wr   = '0;
    e_free = '0;
    if (disp_fire) e_wr[free_idx] = 1'b1;
    if (sel_valid) e_free[sel]    = 1'b1;
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    alu_rs_entry #(.OPW(ALU_OP_WIDTH), .DW(DATA_LEN), .TAG_W(TAG_W)) u_entry (
      .clk       (clk_i),
      .clr       (clr),
      .wr        (e_wr[g]),
      .free      (e_free[g]),
      .wr_op     (disp_op_i),
      .wr_src1   (wr_src1),
      .wr_src2   (wr_src2),
      .wr_tag1   (disp_tag1_i),
      .wr_tag2   (disp_tag2_i),
      .wr_rdy1   (wr_rdy1),
      .wr_rdy2   (wr_rdy2),
      .wr_dst    (disp_dst_i),
      .cdb_valid (cdb_valid_i),
      .cdb_tag   (cdb_tag_i),
      .cdb_data  (cdb_data_i),
      .valid     (e_valid[g]),
      .ready     (e_ready[g]),
      .op        (e_op[g]),
      .src1      (e_src1[g]),
      .src2      (e_src2[g]),
      .dst       (e_dst[g])
    );
  end

`ifdef ALU_RS_OLDEST_FIRST_EN
  // age[i][j] set means entry i was dispatched before entry j.
  logic [ENTRIES-1:0][ENTRIES-1:0] age, age_d;
  logic [ENTRIES-1:0]              blocked;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++)
      for (int j = 0; j < ENTRIES; j++) begin
        if (e_wr[j])                               age_d[i][j] = e_valid[i] & ~e_free[i];
        else if (e_wr[i] || e_free[i] || e_free[j]) age_d[i][j] = 1'b0;
        else                                       age_d[i][j] = age[i][j];
      end
  end

  always_ff @(posedge clk_i) begin
    if (clr) age <= '0;
    else     age <= age_d;
  end

  always_comb begin
    blocked = '0;
    for (int i = 0; i < ENTRIES; i++)
      for (int j = 0; j < ENTRIES; j++)
        if (age[j][i] && e_ready[j]) blocked[i] = 1'b1;
    cand = e_ready & ~blocked;
  end
`else
  assign cand = e_ready;
`endif

  always_comb begin
    sel       = '0;
    sel_valid = ~ex_stall_i & (|cand);
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (cand[i]) sel = ENTRY_SEL'(i);
  end

  always_ff @(posedge clk_i) begin
    if (clr) begin
      issue_valid_o <= 1'b0;
      issue_op_o    <= '0;
      issue_src1_o  <= '0;
      issue_src2_o  <= '0;
      issue_dst_o   <= '0;
    end else if (!ex_stall_i) begin
      issue_valid_o <= sel_valid;
      if (sel_valid) begin
        issue_op_o   <= e_op[sel];
        issue_src1_o <= e_src1[sel];
        issue_src2_o <= e_src2[sel];
        issue_dst_o  <= e_dst[sel];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr) busy_cnt_o <= '0;
    else begin
      case ({disp_fire, sel_valid})
        2'b10:   busy_cnt_o <= busy_cnt_o + 1'b1;
        2'b01:   busy_cnt_o <= busy_cnt_o - 1'b1;
        default: busy_cnt_o <= busy_cnt_o;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Self-checking bench for alu_reservation_station: scoreboard of expected issues plus per-scenario timing checks.
module tb_alu_reservation_station;
  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [5:0]  dst;
  } item_t;

  logic        clk = 1'b0;
  logic        reset, kill, disp_valid, disp_ready;
  logic [3:0]  disp_op;
  logic [31:0] disp_src1, disp_src2;
  logic [5:0]  disp_tag1, disp_tag2, disp_dst;
  logic        disp_rdy1, disp_rdy2;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        ex_stall, issue_valid;
  logic [3:0]  issue_op;
  logic [31:0] issue_src1, issue_src2;
  logic [5:0]  issue_dst;
  logic [2:0]  busy_cnt;

  int    ntests = 0;
  int    nfails = 0;
  item_t sb[$];
  item_t exp_it;
  logic  new_iss = 1'b0;

  always #5 clk = ~clk;

  alu_reservation_station dut (
    .clk_i(clk), .reset_i(reset), .kill_i(kill),
    .disp_valid_i(disp_valid), .disp_ready_o(disp_ready), .disp_op_i(disp_op),
    .disp_src1_i(disp_src1), .disp_src2_i(disp_src2),
    .disp_tag1_i(disp_tag1), .disp_tag2_i(disp_tag2),
    .disp_rdy1_i(disp_rdy1), .disp_rdy2_i(disp_rdy2), .disp_dst_i(disp_dst),
    .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_data_i(cdb_data),
    .ex_stall_i(ex_stall), .issue_valid_o(issue_valid), .issue_op_o(issue_op),
    .issue_src1_o(issue_src1), .issue_src2_o(issue_src2), .issue_dst_o(issue_dst),
    .busy_cnt_o(busy_cnt)
  );

  // A held issue register during a stall is not a new issue.
  always @(posedge clk) new_iss <= !ex_stall && !reset && !kill;

  always @(negedge clk) begin
    if (issue_valid && new_iss) begin
      ntests++;
      if (sb.size() == 0) begin
        nfails++;
        $display("FAIL sb_unexpected_issue got op=%0h dst=%0d, expected no issue", issue_op, issue_dst);
      end else begin
        exp_it = sb.pop_front();
        if ({issue_op, issue_src1, issue_src2, issue_dst} !== exp_it) begin
          nfails++;
          $display("FAIL sb_payload got op=%0h s1=%0h s2=%0h dst=%0d, expected op=%0h s1=%0h s2=%0h dst=%0d",
                   issue_op, issue_src1, issue_src2, issue_dst, exp_it.op, exp_it.s1, exp_it.s2, exp_it.dst);
        end
      end
    end
  end

  function automatic item_t mk(logic [3:0] op, logic [31:0] s1, logic [31:0] s2, logic [5:0] dst);
    item_t it;
    it.op = op; it.s1 = s1; it.s2 = s2; it.dst = dst;
    return it;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
  endtask

  task automatic dispatch(logic [3:0] op, logic [31:0] s1, logic [31:0] s2, logic [5:0] t1,
                          logic [5:0] t2, logic r1, logic r2, logic [5:0] dst);
    disp_valid = 1'b1; disp_op = op; disp_src1 = s1; disp_src2 = s2;
    disp_tag1 = t1; disp_tag2 = t2; disp_rdy1 = r1; disp_rdy2 = r2; disp_dst = dst;
  endtask

  task automatic cdb(logic [5:0] tag, logic [31:0] data);
    cdb_valid = 1'b1; cdb_tag = tag; cdb_data = data;
  endtask

  task automatic test_reset();
    reset = 1'b1; kill = 1'b0; ex_stall = 1'b0;
    idle();
    dispatch(4'h0, 0, 0, 0, 0, 1'b0, 1'b0, 0);
    disp_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    tick(); tick();
    reset = 1'b0;
    ntests++;
    if ({issue_valid, busy_cnt, disp_ready} !== {1'b0, 3'd0, 1'b1}) begin
      nfails++;
      $display("FAIL reset_ctl got iv=%b busy=%0d rdy=%b, expected iv=0 busy=0 rdy=1", issue_valid, busy_cnt, disp_ready);
    end
    ntests++;
    if ({issue_op, issue_src1, issue_src2, issue_dst} !== '0) begin
      nfails++;
      $display("FAIL reset_payload got op=%0h dst=%0d, expected all zero", issue_op, issue_dst);
    end
  endtask

  task automatic test_basic();
    dispatch(4'h1, 32'd5, 32'd7, 0, 0, 1'b1, 1'b1, 6'd3);
    sb.push_back(mk(4'h1, 32'd5, 32'd7, 6'd3));
    tick(); idle();
    ntests++;
    if (issue_valid !== 1'b0 || busy_cnt !== 3'd1) begin
      nfails++;
      $display("FAIL basic_residence got iv=%b busy=%0d, expected iv=0 busy=1", issue_valid, busy_cnt);
    end
    tick();
    ntests++;
    if (issue_valid !== 1'b1) begin
      nfails++;
      $display("FAIL basic_issue got iv=%b, expected 1", issue_valid);
    end
    tick();
    ntests++;
    if (issue_valid !== 1'b0 || busy_cnt !== 3'd0) begin
      nfails++;
      $display("FAIL basic_drain got iv=%b busy=%0d, expected iv=0 busy=0", issue_valid, busy_cnt);
    end
  endtask

  task automatic test_wakeup();
    dispatch(4'h2, 32'd10, 32'd0, 0, 6'd9, 1'b1, 1'b0, 6'd8);
    sb.push_back(mk(4'h2, 32'd10, 32'd4, 6'd8));
    tick(); idle();
    for (int c = 0; c < 2; c++) begin
      if (c == 1) cdb(6'd9, 32'd4);
      ntests++;
      if (issue_valid !== 1'b0) begin
        nfails++;
        $display("FAIL wakeup_early cycle %0d got iv=%b, expected 0", c, issue_valid);
      end
      tick();
    end
    idle();
    ntests++;
    if (issue_valid !== 1'b0) begin
      nfails++;
      $display("FAIL wakeup_edge got iv=%b, expected 0", issue_valid);
    end
    tick();
    ntests++;
    if (issue_valid !== 1'b1 || issue_src2 !== 32'd4) begin
      nfails++;
      $display("FAIL wakeup_issue got iv=%b src2=%0d, expected iv=1 src2=4", issue_valid, issue_src2);
    end
    tick();
  endtask

  task automatic test_same_cycle_capture();
    dispatch(4'h3, 32'h11, 32'd0, 0, 6'd12, 1'b1, 1'b0, 6'd5);
    cdb(6'd12, 32'hFFFF_FFFF);
    sb.push_back(mk(4'h3, 32'h11, 32'hFFFF_FFFF, 6'd5));
    tick(); idle();
    ntests++;
    if (issue_valid !== 1'b0 || busy_cnt !== 3'd1) begin
      nfails++;
      $display("FAIL capture_residence got iv=%b busy=%0d, expected iv=0 busy=1", issue_valid, busy_cnt);
    end
    tick();
    ntests++;
    if (issue_valid !== 1'b1 || issue_src2 !== 32'hFFFF_FFFF) begin
      nfails++;
      $display("FAIL capture_issue got iv=%b src2=%0h, expected iv=1 src2=ffffffff", issue_valid, issue_src2);
    end
    tick();
  endtask

  task automatic test_full();
    // src1 is ready but its stale tag also matches the broadcast; it must not be overwritten.
    for (int k = 0; k < 4; k++) begin
      dispatch(4'(4 + k), 32'(100 + k), 32'd0, 6'd1, 6'd1, 1'b1, 1'b0, 6'(10 + k));
      sb.push_back(mk(4'(4 + k), 32'(100 + k), 32'hABCD, 6'(10 + k)));
      tick();
    end
    dispatch(4'h9, 32'd1, 32'd2, 0, 0, 1'b1, 1'b1, 6'd20);
    ntests++;
    if (disp_ready !== 1'b0 || busy_cnt !== 3'd4) begin
      nfails++;
      $display("FAIL full_state got rdy=%b busy=%0d, expected rdy=0 busy=4", disp_ready, busy_cnt);
    end
    tick(); idle();
    ntests++;
    if (busy_cnt !== 3'd4 || issue_valid !== 1'b0) begin
      nfails++;
      $display("FAIL full_reject got busy=%0d iv=%b, expected busy=4 iv=0", busy_cnt, issue_valid);
    end
    cdb(6'd1, 32'hABCD);
    tick(); idle();
    ntests++;
    if (disp_ready !== 1'b0) begin
      nfails++;
      $display("FAIL full_ready_after_wake got rdy=%b, expected 0", disp_ready);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      ntests++;
      if (issue_valid !== 1'b1 || issue_dst !== 6'(10 + k)) begin
        nfails++;
        $display("FAIL full_drain_%0d got iv=%b dst=%0d, expected iv=1 dst=%0d", k, issue_valid, issue_dst, 10 + k);
      end
    end
    ntests++;
    if (disp_ready !== 1'b1 || busy_cnt !== 3'd0) begin
      nfails++;
      $display("FAIL full_empty got rdy=%b busy=%0d, expected rdy=1 busy=0", disp_ready, busy_cnt);
    end
    tick();
  endtask

  task automatic test_stall();
    dispatch(4'h5, 32'd1, 32'd2, 0, 0, 1'b1, 1'b1, 6'd30);
    sb.push_back(mk(4'h5, 32'd1, 32'd2, 6'd30));
    tick();
    dispatch(4'h6, 32'd3, 32'd4, 0, 0, 1'b1, 1'b1, 6'd31);
    sb.push_back(mk(4'h6, 32'd3, 32'd4, 6'd31));
    tick(); idle();
    ex_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      ntests++;
      if (issue_valid !== 1'b1 || issue_dst !== 6'd30 || busy_cnt !== 3'd1) begin
        nfails++;
        $display("FAIL stall_hold_%0d got iv=%b dst=%0d busy=%0d, expected iv=1 dst=30 busy=1",
                 c, issue_valid, issue_dst, busy_cnt);
      end
    end
    ex_stall = 1'b0;
    tick();
    ntests++;
    if (issue_valid !== 1'b1 || issue_dst !== 6'd31 || busy_cnt !== 3'd0) begin
      nfails++;
      $display("FAIL stall_release got iv=%b dst=%0d busy=%0d, expected iv=1 dst=31 busy=0", issue_valid, issue_dst, busy_cnt);
    end
    tick();
  endtask

  task automatic test_kill();
    ex_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      dispatch(4'h7, 32'(k), 32'(k), 0, 0, 1'b1, 1'b1, 6'(40 + k));
      tick();
    end
    idle();
    ntests++;
    if (busy_cnt !== 3'd3) begin
      nfails++;
      $display("FAIL kill_setup got busy=%0d, expected 3", busy_cnt);
    end
    ex_stall = 1'b0;
    kill = 1'b1;
    dispatch(4'h8, 32'd9, 32'd9, 0, 0, 1'b1, 1'b1, 6'd45);
    tick(); kill = 1'b0; idle();
    ntests++;
    if ({busy_cnt, issue_valid, disp_ready, issue_op} !== {3'd0, 1'b0, 1'b1, 4'h0}) begin
      nfails++;
      $display("FAIL kill_clear got busy=%0d iv=%b rdy=%b op=%0h, expected busy=0 iv=0 rdy=1 op=0",
               busy_cnt, issue_valid, disp_ready, issue_op);
    end
    tick();
    ntests++;
    if (issue_valid !== 1'b0 || busy_cnt !== 3'd0) begin
      nfails++;
      $display("FAIL kill_after got iv=%b busy=%0d, expected iv=0 busy=0", issue_valid, busy_cnt);
    end
  endtask

  task automatic test_age_order();
    logic [5:0] first_dst, second_dst;
    dispatch(4'h8, 32'd1, 32'd1, 0, 0, 1'b1, 1'b1, 6'd50);
    sb.push_back(mk(4'h8, 32'd1, 32'd1, 6'd50));
    tick();
    dispatch(4'h9, 32'd2, 32'd0, 0, 6'd20, 1'b1, 1'b0, 6'd51);
    tick();
    dispatch(4'hA, 32'd3, 32'd3, 0, 0, 1'b1, 1'b1, 6'd52);
    cdb(6'd20, 32'd77);
`ifdef ALU_RS_OLDEST_FIRST_EN
    sb.push_back(mk(4'h9, 32'd2, 32'd77, 6'd51));
    sb.push_back(mk(4'hA, 32'd3, 32'd3, 6'd52));
    first_dst = 6'd51; second_dst = 6'd52;
`else
    sb.push_back(mk(4'hA, 32'd3, 32'd3, 6'd52));
    sb.push_back(mk(4'h9, 32'd2, 32'd77, 6'd51));
    first_dst = 6'd52; second_dst = 6'd51;
`endif
    tick(); idle();
    ntests++;
    if (busy_cnt !== 3'd2) begin
      nfails++;
      $display("FAIL age_setup got busy=%0d, expected 2", busy_cnt);
    end
    tick();
    ntests++;
    if (issue_valid !== 1'b1 || issue_dst !== first_dst) begin
      nfails++;
      $display("FAIL age_first got iv=%b dst=%0d, expected iv=1 dst=%0d", issue_valid, issue_dst, first_dst);
    end
    tick();
    ntests++;
    if (issue_valid !== 1'b1 || issue_dst !== second_dst) begin
      nfails++;
      $display("FAIL age_second got iv=%b dst=%0d, expected iv=1 dst=%0d", issue_valid, issue_dst, second_dst);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_same_cycle_capture();
    test_full();
    test_stall();
    test_kill();
    test_age_order();
    tick();
    ntests++;
    if (sb.size() != 0) begin
      nfails++;
      $display("FAIL sb_leftover got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfails);
    $finish;
  end
endmodule
